// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the memory DMA engine.
// Holds the FSM encoding, transfer modes and I/O addresses.
package mem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam logic [31:0] IO_SWITCHES = 32'hC000_0000;
  localparam logic [31:0] IO_LEDS     = 32'hC000_0004;

  function automatic logic misaligned(
    input logic        m,
    input logic [31:0] s,
    input logic [31:0] d
  );
    return ((m == MODE_COPY) && (s[1:0] != 2'b00)) ||
           (d[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Word DMA engine: copy or fill over a single memory data port.
// Copy costs a READ and a WRITE per word, fill one WRITE per word.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_val,
  output logic [31:0]      mem_a,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] count
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      data_r;
  logic [31:0]      fill_r;
  logic [LEN_W-1:0] len_r;
  logic             mode_r;
  logic             err_r;
  logic [LEN_W-1:0] cnt_nxt;

  assign cnt_nxt = count + ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      data_r  <= '0;
      fill_r  <= '0;
      len_r   <= '0;
      mode_r  <= MODE_COPY;
      err_r   <= 1'b0;
      count   <= '0;
    end else begin
      err_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src;
            dst_ptr <= dst;
            len_r   <= len;
            mode_r  <= mode;
            fill_r  <= fill_val;
            count   <= '0;
            if (misaligned(mode, src, dst))
              err_r <= 1'b1;
            else if (len == '0)
              state <= DONE;
            else if (mode == MODE_FILL)
              state <= WRITE;
            else
              state <= READ;
          end
        end
        READ: begin
          data_r <= mem_rd;
          state  <= WRITE;
        end
        WRITE: begin
          count   <= cnt_nxt;
          dst_ptr <= dst_ptr + 32'd4;
          if (mode_r == MODE_COPY)
            src_ptr <= src_ptr + 32'd4;
          if (cnt_nxt == len_r)
            state <= DONE;
          else if (mode_r == MODE_COPY)
            state <= READ;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset silences the port at once.
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign err    = err_r;
  assign mem_we = (state == WRITE);

  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    case (state)
      READ:  mem_a = src_ptr;
      WRITE: begin
        mem_a  = dst_ptr;
        mem_wd = (mode_r == MODE_FILL) ? fill_r : data_r;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 The module SHALL have parameter LEN_W, default 16, giving the width of the transfer length in words.
REQ-002 The module SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port start  input  1  request a transfer; sampled only in IDLE.
REQ-005 The module SHALL have port mode  input  1  transfer type: 0 = copy, 1 = fill.
REQ-006 The module SHALL have port src  input  32  byte address of the first copy source word.
REQ-007 The module SHALL have port dst  input  32  byte address of the first destination word.
REQ-008 The module SHALL have port len  input  LEN_W  number of 32-bit words to transfer.
REQ-009 The module SHALL have port fill_val  input  32  word written in fill mode.
REQ-010 The module SHALL have port mem_a  output  32  byte address to the unified memory data port.
REQ-011 The module SHALL have port mem_we  output  1  memory write enable.
REQ-012 The module SHALL have port mem_wd  output  32  memory write data.
REQ-013 The module SHALL have port mem_rd  input  32  memory read data, combinational from mem_a in the same cycle.
REQ-014 The module SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-015 The module SHALL have port done  output  1  one-cycle pulse when a transfer completes.
REQ-016 The module SHALL have port err  output  1  one-cycle pulse when a start is rejected.
REQ-017 The module SHALL have port count  output  LEN_W  number of words written in the current or last transfer.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, READ, WRITE and DONE.
REQ-019 In IDLE with start=1, the FSM SHALL latch src, dst, len, mode and fill_val at that edge and clear count.
REQ-020 From IDLE, when src[1:0] is nonzero in copy mode, or dst[1:0] is nonzero in either mode, the FSM SHALL pulse err for one cycle, stay in IDLE and perform no memory access.
REQ-021 From IDLE, when len=0, the FSM SHALL go to DONE with no memory access.
REQ-022 Otherwise the FSM SHALL go to READ in copy mode and to WRITE in fill mode.
REQ-023 In READ, the block SHALL drive mem_a=src_ptr and mem_we=0, capture mem_rd into the data register at the edge, and go to WRITE.
REQ-024 In WRITE, the block SHALL drive mem_a=dst_ptr, mem_we=1 and mem_wd equal to the data register in copy mode or fill_val in fill mode.
REQ-025 At each WRITE edge the block SHALL increment count, add 4 to dst_ptr, and add 4 to src_ptr in copy mode.
REQ-026 Pointer increments SHALL wrap modulo 2^32, so 0xFFFF_FFFC is followed by 0x0000_0000.
REQ-027 From WRITE, the FSM SHALL go to DONE when count+1 equals len, else to READ in copy mode or stay in WRITE in fill mode.
REQ-028 In DONE, the block SHALL assert done for one cycle and then return to IDLE.
REQ-029 Throughput SHALL be 2 cycles per word in copy mode and 1 cycle per word in fill mode.
REQ-030 A start with len=N accepted at edge k SHALL produce done high in cycle k+2N+1 for copy and k+N+1 for fill; for len=0, done SHALL be high in cycle k+1.
REQ-031 The start input SHALL be ignored outside IDLE.
REQ-032 Inputs other than start SHALL NOT be sampled after acceptance.
REQ-033 mem_we SHALL be 0 in every state except WRITE.
REQ-034 In IDLE and DONE, mem_a and mem_wd SHALL be 0.
REQ-035 The block SHALL treat the I/O addresses 0xC000_0000 and 0xC000_0004 as ordinary addresses; it SHALL NOT filter them.

Reset
REQ-036 With reset low, the block SHALL asynchronously force state=IDLE, busy=0, done=0, err=0, count=0, pointers=0 and data register=0.
REQ-037 With reset low, mem_we SHALL be 0 immediately, without waiting for a clock edge.
REQ-038 Reset mid-transfer SHALL abandon the transfer, with no done pulse and no further writes.

Structure
REQ-039 A shared package mem_dma_pkg SHALL hold the state enum (IDLE, READ, WRITE, DONE), the mode constants MODE_COPY=0 and MODE_FILL=1, and the I/O constants IO_SWITCHES=32'hC000_0000 and IO_LEDS=32'hC000_0004.
REQ-040 The design SHALL be a single module with no sub-module.

Verification
REQ-041 Copy, memory words 0..2 = 1, 2, 3, src=0x00, dst=0x40, len=3 -> writes land at 0x40, 0x44, 0x48 = 1, 2, 3; done is high in cycle k+7; count=3.
REQ-042 Fill, dst=0x80, len=4, fill_val=0xDEADBEEF -> mem_we is high for 4 consecutive cycles at 0x80..0x8C; done is high in cycle k+5.
REQ-043 len=0 -> done is high in cycle k+1, mem_we is never 1, and count=0.
REQ-044 Copy with src=0x02 -> err pulses for 1 cycle, busy stays 0, and there is no memory access; a fill with dst=0x41 also produces err.
REQ-045 Fill at dst=0xFFFF_FFFC, len=2 -> writes go to 0xFFFF_FFFC, then 0x0000_0000.
REQ-046 Reset driven low after the 2nd write of a len=5 copy -> mem_we=0 at once, state returns to IDLE, no done pulse, and no further writes; a start pulsed while busy is ignored.
